// File: rtl/ball_score_logic.sv
// ----------------------------------------------------------------------------
// ball_score_logic
//
// Owns the ball and the match state for the pong top level. Once per frame
// (at the first blanking line) it advances the ball, bounces it off the top
// and bottom walls and off the paddles, detects misses, and keeps both 4-bit
// scores. It also produces the ball video term for the current pixel.
//
// Paddle hits are found by coincidence: any visible pixel where the ball and
// a paddle are both lit sets a hit latch, and the next frame tick consumes
// the latch. This matches how the original Pong hardware detected contact.
//
// Ports
//   clk              pixel clock, shared with hvsync_generator
//   reset            synchronous, active-high
//   hpos, vpos       current pixel column / line
//   display_on       high inside the visible area
//   paddle_left_on   left paddle video for the current pixel
//   paddle_right_on  right paddle video for the current pixel
//   ball_on          ball video for the current pixel (combinational)
//   left_score       registered, feeds scores_display.counter_left
//   right_score      registered, feeds scores_display.counter_right
//   game_over        high once either score reaches MAX_SCORE
// ----------------------------------------------------------------------------
module ball_score_logic #(
    parameter int H_VISIBLE    = 256,
    parameter int V_VISIBLE    = 240,
    parameter int BALL_SIZE    = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int MAX_SCORE    = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic       paddle_left_on,
    input  logic       paddle_right_on,
    output logic       ball_on,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic       game_over
);

    localparam logic [8:0] CX         = 9'((H_VISIBLE - BALL_SIZE) / 2);
    localparam logic [8:0] CY         = 9'((V_VISIBLE - BALL_SIZE) / 2);
    localparam logic [8:0] X_MISS_R   = 9'(H_VISIBLE - BALL_SIZE - 1);
    localparam logic [8:0] Y_BOTTOM   = 9'(V_VISIBLE - BALL_SIZE);
    localparam logic [8:0] TICK_LINE  = 9'(V_VISIBLE);
    localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);
    localparam logic [3:0] SCORE_MAX  = 4'(MAX_SCORE);
    localparam logic [9:0] SIZE_W     = 10'(BALL_SIZE);

    typedef enum logic [1:0] {
        ST_SERVE,
        ST_PLAY,
        ST_OVER
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] serve_cnt, serve_cnt_nxt;
    logic [8:0] ball_x, ball_x_nxt;
    logic [8:0] ball_y, ball_y_nxt;
    logic       dir_x, dir_x_nxt;      // 1 = moving right
    logic       dir_y, dir_y_nxt;      // 1 = moving down
    logic [3:0] left_score_nxt, right_score_nxt;
    logic       hit_l, hit_l_nxt;
    logic       hit_r, hit_r_nxt;

    logic       frame_tick;
    logic       missed;
    logic [9:0] hpos_w, vpos_w, bx_w, by_w;

    // First blanking line: the whole visible frame has been drawn with the
    // current position, so updating here keeps every frame consistent.
    assign frame_tick = (hpos == 9'd0) && (vpos == TICK_LINE);

    // Compare in 10 bits so ball_x + BALL_SIZE cannot wrap at the right edge.
    always_comb begin
        hpos_w  = {1'b0, hpos};
        vpos_w  = {1'b0, vpos};
        bx_w    = {1'b0, ball_x};
        by_w    = {1'b0, ball_y};
        ball_on = display_on && (state != ST_OVER)
                  && (hpos_w >= bx_w) && (hpos_w < bx_w + SIZE_W)
                  && (vpos_w >= by_w) && (vpos_w < by_w + SIZE_W);
    end

    assign game_over = (state == ST_OVER);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_SERVE;
            serve_cnt   <= 6'd0;
            ball_x      <= CX;
            ball_y      <= CY;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            left_score  <= 4'd0;
            right_score <= 4'd0;
            hit_l       <= 1'b0;
            hit_r       <= 1'b0;
        end else begin
            state       <= state_nxt;
            serve_cnt   <= serve_cnt_nxt;
            ball_x      <= ball_x_nxt;
            ball_y      <= ball_y_nxt;
            dir_x       <= dir_x_nxt;
            dir_y       <= dir_y_nxt;
            left_score  <= left_score_nxt;
            right_score <= right_score_nxt;
            hit_l       <= hit_l_nxt;
            hit_r       <= hit_r_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: everything except the hit latches moves only on
    // the frame tick.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        serve_cnt_nxt   = serve_cnt;
        ball_x_nxt      = ball_x;
        ball_y_nxt      = ball_y;
        dir_x_nxt       = dir_x;
        dir_y_nxt       = dir_y;
        left_score_nxt  = left_score;
        right_score_nxt = right_score;
        missed          = 1'b0;

        // Latches collect contact during the frame and are consumed (then
        // cleared) by the tick.
        hit_l_nxt = frame_tick ? 1'b0 : (hit_l | (ball_on & paddle_left_on));
        hit_r_nxt = frame_tick ? 1'b0 : (hit_r | (ball_on & paddle_right_on));

        if (frame_tick) begin
            case (state)
                ST_SERVE: begin
                    if (serve_cnt == SERVE_LAST) begin
                        state_nxt     = ST_PLAY;
                        serve_cnt_nxt = 6'd0;
                    end else begin
                        serve_cnt_nxt = serve_cnt + 6'd1;
                    end
                end

                ST_PLAY: begin
                    // Horizontal: a hit outranks a miss on the same tick, and
                    // only the paddle the ball is heading toward counts.
                    if (hit_l && !dir_x) begin
                        dir_x_nxt  = 1'b1;
                        ball_x_nxt = ball_x + 9'd2;
                    end else if (hit_r && dir_x) begin
                        dir_x_nxt  = 1'b0;
                        ball_x_nxt = ball_x - 9'd2;
                    end else if (!dir_x && ball_x < 9'd2) begin
                        missed    = 1'b1;
                        dir_x_nxt = 1'b0;    // next serve heads to the loser
                        if (right_score != SCORE_MAX)
                            right_score_nxt = right_score + 4'd1;
                    end else if (dir_x && ball_x >= X_MISS_R) begin
                        missed    = 1'b1;
                        dir_x_nxt = 1'b1;
                        if (left_score != SCORE_MAX)
                            left_score_nxt = left_score + 4'd1;
                    end else begin
                        ball_x_nxt = dir_x ? ball_x + 9'd2 : ball_x - 9'd2;
                    end

                    // Vertical: wall bounce turns around in place so the
                    // ball never leaves 0..V_VISIBLE-BALL_SIZE.
                    if (!dir_y && ball_y == 9'd0) begin
                        dir_y_nxt  = 1'b1;
                        ball_y_nxt = 9'd1;
                    end else if (dir_y && ball_y == Y_BOTTOM) begin
                        dir_y_nxt  = 1'b0;
                        ball_y_nxt = ball_y - 9'd1;
                    end else begin
                        ball_y_nxt = dir_y ? ball_y + 9'd1 : ball_y - 9'd1;
                    end

                    // A point recentres the ball; dir_y carries over so
                    // successive serves do not all look the same.
                    if (missed) begin
                        ball_x_nxt    = CX;
                        ball_y_nxt    = CY;
                        dir_y_nxt     = dir_y;
                        serve_cnt_nxt = 6'd0;
                        if (left_score_nxt == SCORE_MAX ||
                            right_score_nxt == SCORE_MAX)
                            state_nxt = ST_OVER;
                        else
                            state_nxt = ST_SERVE;
                    end
                end

                default: begin
                    // ST_OVER: frozen until reset
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_score_logic.sv
module tb_ball_score_logic;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] hpos = '0;
    logic [8:0] vpos = '0;
    logic       display_on = 1'b0;
    logic       paddle_left_on = 1'b0;
    logic       paddle_right_on = 1'b0;
    logic       ball_on;
    logic [3:0] left_score, right_score;
    logic       game_over;

    always #5 clk = ~clk;

    ball_score_logic dut (
        .clk            (clk),
        .reset          (reset),
        .hpos           (hpos),
        .vpos           (vpos),
        .display_on     (display_on),
        .paddle_left_on (paddle_left_on),
        .paddle_right_on(paddle_right_on),
        .ball_on        (ball_on),
        .left_score     (left_score),
        .right_score    (right_score),
        .game_over      (game_over)
    );

    typedef struct {
        string      name;
        int         h;
        int         v;
        logic       on;
        logic [3:0] l;
        logic [3:0] r;
        logic       go;
    } exp_t;

    exp_t sb[$];
    logic probe_vld = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;

    // Reference model of the match, stepped once per issued frame tick.
    int m_x, m_y, m_st, m_cnt, m_l, m_r;
    bit m_dx, m_dy;

    // Monitor: compares whenever the stimulus side marks a probe pixel.
    always @(negedge clk) begin
        if (probe_vld) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL scoreboard: probe with no expected entry");
            end else begin
                e = sb.pop_front();
                if (ball_on !== e.on || left_score !== e.l ||
                    right_score !== e.r || game_over !== e.go) begin
                    n_fails++;
                    $display("FAIL %s h=%0d v=%0d: got on=%0b score=%0d/%0d go=%0b, expected on=%0b score=%0d/%0d go=%0b",
                             e.name, e.h, e.v, ball_on, left_score, right_score, game_over,
                             e.on, e.l, e.r, e.go);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = 126; m_y = 118; m_dx = 1; m_dy = 1;
        m_st = 0; m_cnt = 0; m_l = 0; m_r = 0;
    endtask

    task automatic model_step(input bit hl, input bit hr);
        bit miss;
        miss = 0;
        case (m_st)
            0: begin
                if (m_cnt == 59) begin m_st = 1; m_cnt = 0; end
                else m_cnt++;
            end
            1: begin
                if (hl && !m_dx) begin m_dx = 1; m_x += 2; end
                else if (hr && m_dx) begin m_dx = 0; m_x -= 2; end
                else if (!m_dx && m_x < 2) begin m_r++; m_dx = 0; miss = 1; end
                else if (m_dx && m_x >= 251) begin m_l++; m_dx = 1; miss = 1; end
                else m_x += m_dx ? 2 : -2;
                if (miss) begin
                    m_x = 126; m_y = 118; m_cnt = 0;
                    m_st = (m_l == 11 || m_r == 11) ? 2 : 0;
                end else if (!m_dy && m_y == 0) begin m_dy = 1; m_y = 1; end
                else if (m_dy && m_y == 236) begin m_dy = 0; m_y--; end
                else m_y += m_dy ? 1 : -1;
            end
            default: ;
        endcase
    endtask

    task automatic probe(input string nm, input int h, input int v, input bit disp,
                         input bit exp_on, input int l, input int r, input bit go);
        hpos = 9'(h); vpos = 9'(v); display_on = disp;
        paddle_left_on = 1'b0; paddle_right_on = 1'b0;
        sb.push_back('{nm, h, v, exp_on, 4'(l), 4'(r), go});
        probe_vld = 1'b1;
        cyc();
        probe_vld = 1'b0;
    endtask

    // Ball square at (x,y): lit inside, dark just outside, dark when blanked.
    task automatic check_ball(input string nm, input int x, input int y,
                              input int l, input int r, input bit go);
        bit on;
        on = !go;
        probe(nm, x, y, 1, on, l, r, go);
        probe(nm, x + 3, y + 3, 1, on, l, r, go);
        if (x > 0)       probe(nm, x - 1, y, 1, 0, l, r, go);
        if (x + 4 < 256) probe(nm, x + 4, y, 1, 0, l, r, go);
        if (y > 0)       probe(nm, x, y - 1, 1, 0, l, r, go);
        if (y + 4 < 240) probe(nm, x, y + 4, 1, 0, l, r, go);
        probe(nm, x, y, 0, 0, l, r, go);
    endtask

    task automatic track(input string nm);
        check_ball(nm, m_x, m_y, m_l, m_r, m_st == 2);
    endtask

    // One frame: optional paddle contact on the ball's pixel, then the tick.
    task automatic frame(input bit pl, input bit pr);
        probe_vld = 1'b0;
        if (pl || pr) begin
            hpos = 9'(m_x); vpos = 9'(m_y); display_on = 1'b1;
            paddle_left_on = pl; paddle_right_on = pr;
            cyc();
        end
        hpos = 9'd0; vpos = 9'd240; display_on = 1'b0;
        paddle_left_on = 1'b0; paddle_right_on = 1'b0;
        cyc();
        hpos = 9'd300; vpos = 9'd0;
        model_step(pl, pr);
    endtask

    task automatic bound_fail(input string nm);
        n_fails++;
        $display("FAIL %s: frame budget exhausted (m_x=%0d m_y=%0d score=%0d/%0d)",
                 nm, m_x, m_y, m_l, m_r);
    endtask

    function automatic bit auto_l();
        return !m_dx && m_x == 0;
    endfunction

    function automatic bit auto_r();
        return m_dx && m_x == 252;
    endfunction

    // Rally until the scores reach the targets: a side that still needs to
    // concede points leaves its paddle off, otherwise it returns at the edge.
    task automatic play_until(input int tl, input int tr);
        int g;
        bit pl, pr;
        g = 0;
        while ((m_l < tl || m_r < tr) && g < 6000) begin
            pl = auto_l() && (m_r >= tr);
            pr = auto_r() && (m_l >= tl);
            frame(pl, pr);
            track("rally");
            g++;
        end
        if (g >= 6000) bound_fail("play_until");
    endtask

    initial begin
        int g;
        model_reset();
        cyc(); cyc();
        reset = 1'b0;

        // Reset state and serve delay
        check_ball("reset", 126, 118, 0, 0, 0);
        repeat (60) frame(0, 0);
        check_ball("serve60", 126, 118, 0, 0, 0);
        frame(0, 0);
        check_ball("serve61", 128, 119, 0, 0, 0);
        frame(0, 0);
        check_ball("serve62", 130, 120, 0, 0, 0);

        // Miss right with no paddles
        g = 0;
        while (m_l == 0 && g < 200) begin frame(0, 0); track("to_right"); g++; end
        if (g >= 200) bound_fail("to_right");
        check_ball("recentre", 126, 118, 1, 0, 0);
        repeat (60) frame(0, 0);
        check_ball("hold60", 126, 118, 1, 0, 0);
        frame(0, 0);
        check_ball("reserve", 128, 119, 1, 0, 0);

        // Both paddles at once while moving right: only the right one acts
        g = 0;
        while (!(m_x == 200 && m_dx) && g < 200) begin frame(0, 0); g++; end
        if (g >= 200) bound_fail("to_200");
        frame(1, 1);
        check_ball("both_hit", 198, m_y, 1, 0, 0);

        // Left paddle hit at x=10
        g = 0;
        while (!(m_x == 10 && !m_dx) && g < 200) begin frame(0, 0); track("to_10"); g++; end
        if (g >= 200) bound_fail("to_10");
        frame(1, 0);
        check_ball("lhit", 12, m_y, 1, 0, 0);
        frame(0, 0);
        check_ball("after_lhit", 14, m_y, 1, 0, 0);

        // Endless rally (edge hits, which also beat the miss) to the top wall
        g = 0;
        while (!(m_st == 1 && m_y == 1 && !m_dy) && g < 1500) begin
            frame(auto_l(), auto_r()); track("to_top"); g++;
        end
        if (g >= 1500) bound_fail("to_top");
        frame(auto_l(), auto_r());
        check_ball("top0", m_x, 0, 1, 0, 0);
        frame(auto_l(), auto_r());
        check_ball("top1", m_x, 1, 1, 0, 0);
        frame(auto_l(), auto_r());
        check_ball("top2", m_x, 2, 1, 0, 0);

        // Scores 3/5, then reset mid-play
        play_until(3, 5);
        g = 0;
        while (!(m_st == 1 && m_x != 126) && g < 200) begin frame(0, 0); g++; end
        if (g >= 200) bound_fail("to_play");
        repeat (5) frame(0, 0);
        track("pre_reset");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        model_reset();
        check_ball("rst_mid", 126, 118, 0, 0, 0);
        repeat (60) frame(0, 0);
        check_ball("rst_hold", 126, 118, 0, 0, 0);
        frame(0, 0);
        check_ball("rst_serve", 128, 119, 0, 0, 0);

        // Left wins 11-0, then everything freezes
        play_until(11, 0);
        check_ball("go", 126, 118, 11, 0, 1);
        probe("go_corner", 0, 0, 1, 0, 11, 0, 1);
        for (int i = 0; i < 200; i++) begin
            frame(1, 1);
            if (i % 50 == 49) track("go_hold");
        end
        check_ball("go_200", 126, 118, 11, 0, 1);

        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ball_score_logic.md
# ball_score_logic

Owns the ball and the match state for the pong top level: per-frame ball motion, wall and paddle bounces, miss detection, and the two 4-bit score counters. It sits directly upstream of `scores_display`, replacing the constant left/right score registers, and produces the `ball_on` video term the top level ORs into `rgb`. It consumes the pixel position from `hvsync_generator` and the paddle video terms for coincidence-based hit detection, as the original Pong hardware does.

## Interface

Parameters:
- `H_VISIBLE`, 256, visible pixels per line.
- `V_VISIBLE`, 240, visible lines per frame.
- `BALL_SIZE`, 4, ball edge in pixels; the ball is square.
- `SERVE_FRAMES`, 60, frames the ball holds at the centre before each serve.
- `MAX_SCORE`, 11, score that ends the match.

Ports:
- `clk` in 1: pixel clock, the same clock as `hvsync_generator`.
- `reset` in 1: synchronous, active-high.
- `hpos` in 9: current pixel column.
- `vpos` in 9: current line.
- `display_on` in 1: high in the visible area.
- `paddle_left_on` in 1: left paddle video for the current pixel.
- `paddle_right_on` in 1: right paddle video for the current pixel.
- `ball_on` out 1: ball video for the current pixel.
- `left_score` out 4: feeds `scores_display.counter_left`.
- `right_score` out 4: feeds `scores_display.counter_right`.
- `game_over` out 1: high once either score reaches `MAX_SCORE`.

## Operation

- **Frame tick:** pulses for one cycle when `hpos==0 && vpos==V_VISIBLE` (first blank line). All motion and score updates happen only on the tick.
- **Registers:**
  - `ball_x[8:0]`, `ball_y[8:0]`.
  - `dir_x`: 1 = right, moving 2 px/frame.
  - `dir_y`: 1 = down, moving 1 px/frame.
  - `serve_cnt[5:0]`, `state`, and both scores.
- **Centre position:** `CX=(H_VISIBLE-BALL_SIZE)/2` (126) and `CY=(V_VISIBLE-BALL_SIZE)/2` (118).
- **States:**
  - **SERVE:** ball held at (CX,CY). `serve_cnt` increments per tick. When it reaches `SERVE_FRAMES-1`, the tick moves to PLAY and clears `serve_cnt`.
  - **PLAY:** per tick, evaluated in this priority order:
    1. **Paddle hit.** `hit_l && !dir_x` sets `dir_x=1`. `hit_r && dir_x` sets `dir_x=0`. The ball moves 2 px in the new direction on the same tick, and no miss is checked.
    2. **Miss left.** `!dir_x && ball_x<2`: `right_score++`, `dir_x=0` (serve toward the player who conceded), then SERVE.
    3. **Miss right.** `dir_x && ball_x>=H_VISIBLE-BALL_SIZE-1`: `left_score++`, `dir_x=1`, then SERVE.
    4. **Otherwise:** `ball_x ±= 2`.
  - **Vertical motion in PLAY:** applied independently of the x rules.
    - `!dir_y && ball_y==0`: set `dir_y=1`, `ball_y=1`.
    - `dir_y && ball_y==V_VISIBLE-BALL_SIZE`: set `dir_y=0`, `ball_y` decrements by 1.
    - Otherwise `ball_y ±= 1`.
  - **GAME_OVER:** entered instead of SERVE when an increment makes a score equal `MAX_SCORE`. Ball is frozen, `ball_on=0`, scores are held. Only `reset` exits this state.
- **Hit latches:**
  - `hit_l` sets on any cycle with `ball_on && paddle_left_on`.
  - `hit_r` sets on any cycle with `ball_on && paddle_right_on`.
  - Both clear on the cycle after each tick; they are sampled by the tick.
- **Scores:**
  - Never exceed `MAX_SCORE`.
  - No increment occurs in SERVE or GAME_OVER.
  - `dir_y` is preserved across serves.
- **`ball_on`:** `display_on && state!=GAME_OVER && hpos>=ball_x && hpos<ball_x+BALL_SIZE && vpos>=ball_y && vpos<ball_y+BALL_SIZE`.
  - Compare in 10 bits so `ball_x+BALL_SIZE` cannot wrap.

## Timing

- **Reset values:**
  - `state=SERVE`, `serve_cnt=0`, `ball_x=126`, `ball_y=118`, `dir_x=1`, `dir_y=1`.
  - Both scores 0, `game_over=0`, `hit_l=hit_r=0`.
- **`ball_on`:** combinational from registered position and the current `hpos`/`vpos`. Zero latency, so it is pixel-aligned with the other video terms.
- **Position, direction, scores, `game_over`:** registered, changing only on the cycle after the tick. `scores_display` therefore sees stable values for the whole visible frame.
- **First serve:** the ball first moves on the tick after 60 SERVE ticks, i.e. tick #61 after reset.
- **Reset in any state:** on the next edge, `reset` restores all reset values and abandons any in-flight hit latch or serve count.
- **Simultaneous hit and miss:** the hit wins.
- **Simultaneous `hit_l` and `hit_r`:** only the one matching `dir_x` acts.

## Test plan

- **Reset and serve delay:**
  - Stimulus: reset, then run 60 frames.
  - Required: `ball_x=126`, `ball_y=118`, scores 0/0, `ball_on=1` exactly at pixels 126..129 × 118..121.
  - After tick #61: (128,119); after tick #62: (130,120).
- **Top bounce:**
  - Stimulus: force `dir_y=0` and `ball_y=1` via play.
  - Required: the next ticks give `ball_y=0`, then `ball_y=1` with `dir_y=1`; `ball_y` is never negative.
- **Paddle hit:**
  - Stimulus: assert `paddle_left_on` over the ball's pixels while `dir_x=0` and `ball_x=10`.
  - Required: after the tick, `dir_x=1`, `ball_x=12`, no score change, latch cleared.
- **Miss right:**
  - Stimulus: let the ball travel right with no paddles.
  - Required: when `ball_x>=251` on a tick, `left_score` goes 0→1, the ball recentres to (126,118), `dir_x=1`, and the 60-frame hold restarts.
- **Game over:**
  - Stimulus: preload `left_score=10` via 10 misses, then cause one more miss.
  - Required: `left_score=11`, `game_over=1`, `ball_on=0` for the whole frame, and no further change for 200 frames.
- **Reset mid-play:**
  - Stimulus: assert `reset` for 1 cycle with scores 3/5 and the ball in motion.
  - Required: next cycle shows scores 0/0, `ball_x=126`, `ball_y=118`, `state=SERVE`, `game_over=0`.
